// File: rtl/multicycle_seq_if.sv
// Memory handshake bundle between the multicycle sequencer and the
// instruction/data memories.
//   imem_req  sequencer -> imem : instruction fetch request
//   imem_ack  imem -> sequencer : instruction word valid this cycle
//   instr_op  imem -> sequencer : opcode field of the fetched word
//   dm_req    sequencer -> dmem : data-memory request
//   dm_we     sequencer -> dmem : write qualifier, valid with dm_req
//   dm_ack    dmem -> sequencer : transfer complete
interface multicycle_seq_if #(
  parameter int OPW = 6
);
  logic           imem_req;
  logic           imem_ack;
  logic [OPW-1:0] instr_op;
  logic           dm_req;
  logic           dm_we;
  logic           dm_ack;

  modport master (
    output imem_req, dm_req, dm_we,
    input  imem_ack, instr_op, dm_ack
  );

  modport slave (
    input  imem_req, dm_req, dm_we,
    output imem_ack, instr_op, dm_ack
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB, drives the register-file / data-memory
// write enables and the ALU select, and traps on illegal opcodes or on a
// memory that does not acknowledge within TIMEOUT cycles.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       begin execution (sampled only in IDLE)
//   mem         memory handshake bundle (master side)
//   ir_we       latch instruction register (fetch ack cycle)
//   alu_op      00 pass, 01 add, 10 sub
//   rf_we       register-file write enable
//   pc_inc      one-cycle pulse when an instruction retires
//   halted, err terminal status flags
//   retired     retired-instruction count (wraps)
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_req high, waiting for imem_ack
// DECODE | classify latched opcode
// EXEC   | ALU operation
// MEM    | dm_req high, waiting for dm_ack
// WB     | register-file write, retire
// HALT   | HALT executed, terminal until reset
// ERR    | illegal opcode or memory timeout, terminal until reset
module multicycle_seq #(
  parameter int OPW     = 6,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  multicycle_seq_if.master mem,
  output logic            ir_we,
  output logic [1:0]      alu_op,
  output logic            rf_we,
  output logic            pc_inc,
  output logic            halted,
  output logic            err,
  output logic [CNTW-1:0] retired
);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
  localparam logic [OPW-1:0] OP_STORE = OPW'(3);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(4);
  localparam logic [OPW-1:0] OP_HALT  = {OPW{1'b1}};

  // Counter must hold TIMEOUT itself (it steps once on the final wait cycle).
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [WW-1:0]  wait_q;
  logic           wait_last;
  logic           waiting;
  logic           retire;

  // Last permitted wait cycle: a missing ack here sends the FSM to ERR.
  assign wait_last = (TIMEOUT != 0) && (wait_q == TO_LAST);
  assign waiting   = ((state_q == S_FETCH) && !mem.imem_ack) ||
                     ((state_q == S_MEM)   && !mem.dm_ack);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ack)   state_d = S_DECODE;
        else if (wait_last) state_d = S_ERR;
      end
      S_DECODE: begin
        if (op_q == OP_NOP)
          state_d = S_FETCH;
        else if (op_q == OP_ADD || op_q == OP_SUB ||
                 op_q == OP_LOAD || op_q == OP_STORE)
          state_d = S_EXEC;
        else if (op_q == OP_HALT)
          state_d = S_HALT;
        else
          state_d = S_ERR;
      end
      S_EXEC: begin
        if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEM;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (mem.dm_ack)     state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
        else if (wait_last) state_d = S_ERR;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dm_req   = 1'b0;
    mem.dm_we    = 1'b0;
    ir_we        = 1'b0;
    alu_op       = 2'b00;
    rf_we        = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_we        = mem.imem_ack;
      end
      S_DECODE: retire = (op_q == OP_NOP);
      S_EXEC:   alu_op = (op_q == OP_SUB) ? 2'b10 : 2'b01;
      S_MEM: begin
        mem.dm_req = 1'b1;
        mem.dm_we  = (op_q == OP_STORE);
        retire     = mem.dm_ack && (op_q == OP_STORE);
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_HALT:   halted = 1'b1;
      S_ERR:    err    = 1'b1;
      default:  ;
    endcase
  end

  assign pc_inc = retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      wait_q  <= '0;
      retired <= '0;
    end else begin
      if (state_q == S_FETCH && mem.imem_ack)
        op_q <= mem.instr_op;

      // Restart the wait count whenever a request state is (re)entered.
      if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
        wait_q <= '0;
      else if (TIMEOUT != 0 && waiting)
        wait_q <= wait_q + 1'b1;

      if (retire)
        retired <= retired + 1'b1;
    end
  end

endmodule
